dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port: accepts load/store requests, services them from an internal 32-word store with a programmable number of wait states, and returns completion through a valid/ready response channel.
- Sits between the CPU data-access initiator and the backing storage, replacing the zero-latency combinational data memory.
- Allows multi-cycle memory timing and alignment-error signalling to be exercised.

---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared constants for the data-memory responder.
//   - FSM state encodings (legacy-compatible 2-bit constants)
//   - default address/data widths
//   - alignment-check width and a helper to test word alignment
package dmem_responder_pkg;

  // Default geometry: 7-bit byte address -> 32 words of 32 bits.
  localparam int unsigned DefAddrW = 7;
  localparam int unsigned DefDataW = 32;

  // Number of byte-offset LSBs that must be zero for a word access.
  localparam int unsigned AlignW = 2;

  // Wait-state counter width; supports latencies up to 15.
  localparam int unsigned CntW = 4;

  // Responder FSM encoding.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // True when the byte-offset bits select a whole word.
  function automatic logic is_aligned(input logic [AlignW-1:0] lsb);
    return (lsb == '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage for the data-memory responder.
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low clear of every word
//   we_i     synchronous write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  combinational read data (value before any write on this edge)
module dmem_array #(
  parameter int unsigned IdxW  = 5,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IdxW-1:0]  waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [IdxW-1:0]  raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << IdxW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data port.
// Accepts one load/store at a time from IDLE, waits a fixed number of cycles
// (READ_LAT for loads, WRITE_LAT for stores; legal 1..15), then presents the
// response until the initiator takes it.
//   clock       rising-edge clock
//   reset       asynchronous active-low reset (clears FSM and storage)
//   req_valid   request present            req_ready  accepting this cycle
//   req_write   1 = store, 0 = load        req_addr   byte address
//   req_wdata   store data
//   resp_valid  response available         resp_ready initiator consumes it
//   resp_rdata  load data (0 for stores / errors)
//   resp_err    request was misaligned
//   busy        FSM not in IDLE
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned IdxW = ADDR_W - AlignW;

  // Counter preload is LAT-1: the accepting edge itself is the first of the
  // LAT edges, so LAT=1 goes straight to RESP.
  localparam logic [CntW-1:0] RdLatM1 = CntW'(READ_LAT - 1);
  localparam logic [CntW-1:0] WrLatM1 = CntW'(WRITE_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              aligned;
  logic [IdxW-1:0]   idx;
  logic [CntW-1:0]   lat_m1;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign accept  = req_valid && (state_q == StIdle);
  assign aligned = is_aligned(req_addr[AlignW-1:0]);
  assign idx     = req_addr[ADDR_W-1:AlignW];
  assign lat_m1  = req_write ? WrLatM1 : RdLatM1;
  // Stores commit on the accepting edge so any later load sees them.
  assign mem_we  = accept && aligned && req_write;

  dmem_array #(
    .IdxW  (IdxW),
    .DataW (DATA_W)
  ) u_array (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .waddr_i (idx),
    .wdata_i (req_wdata),
    .raddr_i (idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // mem_rdata is the pre-write value; stores and errors return 0.
          rdata_d = (aligned && !req_write) ? mem_rdata : '0;
          err_d   = !aligned;
          cnt_d   = lat_m1;
          state_d = (lat_m1 == '0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        // Leave on the edge where the counter steps down to zero.
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  // Response fields are only meaningful while resp_valid is high.
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int ReadLat  = 2;
  localparam int WriteLat = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference storage: 32 words, indexed by byte address / 4.
  logic [31:0] model_mem [32];

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  dmem_responder dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
  endfunction

  // Expected response from the behavioural rules; also commits stores.
  task automatic model_step(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                            output logic [31:0] exp_data, output logic exp_err,
                            output int exp_lat);
    int idx;
    idx      = int'(addr) / 4;
    exp_err  = (int'(addr) % 4) != 0;
    exp_lat  = wr ? WriteLat : ReadLat;
    exp_data = (exp_err || wr) ? 32'h0 : model_mem[idx];
    if (!exp_err && wr) model_mem[idx] = wd;
  endtask

  // One transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic txn(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                     input int hold, input logic [31:0] exp_data, input logic exp_err,
                     input int exp_lat);
    int          n;
    bit          seen;
    logic [31:0] first;
    chk("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_wdata = ~wd;
    seen = 0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (resp_valid) seen = 1;
    end
    chk("latency", n, seen ? exp_lat : -1);
    if (!seen) begin
      resp_ready = 1'b1;
      return;
    end
    chk("resp_rdata", resp_rdata, exp_data);
    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    chk("busy_resp", {31'b0, busy}, 32'd1);
    first = resp_rdata;
    if (hold > 0) begin
      // Offer another request while backpressured; it must be ignored.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 7'h20;
      req_wdata = 32'hBAD0BAD0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk("bp_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_stable", resp_rdata, first);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    chk("post_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", {31'b0, resp_err}, 32'd0);
    chk("post_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_clear();
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] ed;
    logic        ee;
    int          el;
    int          accepts;
    int          last_acc;
    int          min_gap;
    logic [6:0]  ra;
    logic        rw;
    logic [31:0] rd;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    model_clear();

    apply_reset();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);

    //          wr    addr   wdata         hold data          err   lat
    vecs[0]  = '{1'b0, 7'h10, 32'h0,        0, 32'h00000000, 1'b0, 2};
    vecs[1]  = '{1'b1, 7'h14, 32'hDEADBEEF, 0, 32'h00000000, 1'b0, 1};
    vecs[2]  = '{1'b0, 7'h14, 32'h0,        0, 32'hDEADBEEF, 1'b0, 2};
    vecs[3]  = '{1'b1, 7'h15, 32'h12345678, 0, 32'h00000000, 1'b1, 1};
    vecs[4]  = '{1'b0, 7'h14, 32'h0,        0, 32'hDEADBEEF, 1'b0, 2};
    vecs[5]  = '{1'b0, 7'h16, 32'h0,        0, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{1'b0, 7'h14, 32'h0,        5, 32'hDEADBEEF, 1'b0, 2};
    vecs[7]  = '{1'b1, 7'h7C, 32'hA5A5A5A5, 0, 32'h00000000, 1'b0, 1};
    vecs[8]  = '{1'b1, 7'h00, 32'h5A5A5A5A, 0, 32'h00000000, 1'b0, 1};
    vecs[9]  = '{1'b0, 7'h7C, 32'h0,        0, 32'hA5A5A5A5, 1'b0, 2};
    vecs[10] = '{1'b0, 7'h00, 32'h0,        2, 32'h5A5A5A5A, 1'b0, 2};
    vecs[11] = '{1'b0, 7'h7F, 32'h0,        0, 32'h00000000, 1'b1, 2};

    for (int v = 0; v < 12; v++) begin
      txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hold,
          vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat);
      model_step(vecs[v].wr, vecs[v].addr, vecs[v].wdata, ed, ee, el);
    end

    // Back-to-back loads with req_valid held high: one accept per LAT+1 cycles.
    accepts  = 0;
    last_acc = -100;
    min_gap  = 1000;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 7'h00;
    resp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_valid && req_ready) begin
        if (accepts > 0 && c - last_acc < min_gap) min_gap = c - last_acc;
        accepts++;
        last_acc = c;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    chk("b2b_min_gap", min_gap, ReadLat + 1);
    chk("b2b_accepts", accepts, 30 / (ReadLat + 1));
    for (int c = 0; c < 10 && busy; c++) @(negedge clock);
    chk("b2b_drain", {31'b0, busy}, 32'd0);

    // Reset during the WAIT cycle of a load: response must never appear.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 7'h14;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("mid_wait_busy", {31'b0, busy}, 32'd1);
    chk("mid_wait_valid", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      chk("mid_rst_hold_valid", {31'b0, resp_valid}, 32'd0);
    end
    reset = 1'b1;
    model_clear();
    repeat (3) begin
      @(negedge clock);
      chk("mid_after_valid", {31'b0, resp_valid}, 32'd0);
    end
    model_step(1'b0, 7'h14, 32'h0, ed, ee, el);
    txn(1'b0, 7'h14, 32'h0, 0, ed, ee, el);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      ra = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      model_step(rw, ra, rd, ed, ee, el);
      txn(rw, ra, rd, int'($urandom_range(0, 3)), ed, ee, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
